// File: rtl/ofdmbbp_rx_cmd_sched.sv
// Receive-command scheduler: pops host commands, arms on packet detect, drives the receiver
// handshake/start, replays the command `repeat` times. Option: OFDMBBP_RX_SCHED_RUN_WDOG_EN adds a RUN watchdog.
module ofdmbbp_rx_cmd_sched #(
  parameter int TIMEOUT_W = 24,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_enable,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 cfg_abort,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_data,
  input  logic                 packet_detect,
  output logic                 rx_cmd_valid,
  input  logic                 rx_cmd_ready,
  output logic [7:0]           rx_cmd_length,
  output logic [1:0]           rx_cmd_mode,
  output logic [6:0]           rx_cmd_seed,
  output logic                 rx_start,
  input  logic                 rx_done,
  output logic                 busy,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     pkt_count,
  output logic [CNT_W-1:0]     timeout_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_ISSUE = 3'd2,
    S_START = 3'd3,
    S_RUN   = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  state_t               state_q;
  logic [7:0]           pause_q;
  logic [6:0]           repeat_left;
  logic [7:0]           pause_cnt;
  logic [TIMEOUT_W-1:0] timer;
  logic                 timer_hit;

  assign timer_hit = (cfg_timeout != '0) && (timer == cfg_timeout - TIMEOUT_W'(1));
  assign cmd_ready = !rst && !cfg_abort && cfg_enable && cmd_valid && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign state     = state_q;

  // Abort overrides every other event; PAUSE occupies max(pause,1) cycles before the next ARM or IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rx_cmd_valid  <= 1'b0;
      rx_start      <= 1'b0;
      rx_cmd_length <= '0;
      rx_cmd_mode   <= '0;
      rx_cmd_seed   <= '0;
      pause_q       <= '0;
      repeat_left   <= '0;
      pause_cnt     <= '0;
      timer         <= '0;
      pkt_count     <= '0;
      timeout_count <= '0;
    end else if (cfg_abort) begin
      state_q      <= S_IDLE;
      rx_cmd_valid <= 1'b0;
      rx_start     <= 1'b0;
      repeat_left  <= '0;
      pause_cnt    <= '0;
      timer        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_ready) begin
            pause_q       <= cmd_data[31:24];
            repeat_left   <= cmd_data[23:17];
            rx_cmd_seed   <= cmd_data[16:10];
            rx_cmd_mode   <= cmd_data[9:8];
            rx_cmd_length <= cmd_data[7:0];
            timer         <= '0;
            state_q       <= S_ARM;
          end
        end
        S_ARM: begin
          timer <= timer + TIMEOUT_W'(1);
          if (packet_detect) begin
            rx_cmd_valid <= 1'b1;
            state_q      <= S_ISSUE;
          end else if (timer_hit) begin
            timeout_count <= (&timeout_count) ? timeout_count : timeout_count + CNT_W'(1);
            repeat_left   <= '0;
            state_q       <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (rx_cmd_ready) begin
            rx_cmd_valid <= 1'b0;
            rx_start     <= 1'b1;
            state_q      <= S_START;
          end
        end
        S_START: begin
          rx_start <= 1'b0;
          timer    <= '0;
          state_q  <= S_RUN;
        end
        S_RUN: begin
`ifdef OFDMBBP_RX_SCHED_RUN_WDOG_EN
          timer <= timer + TIMEOUT_W'(1);
          if (rx_done) begin
            pkt_count <= (&pkt_count) ? pkt_count : pkt_count + CNT_W'(1);
            pause_cnt <= pause_q;
            state_q   <= S_PAUSE;
          end else if (timer_hit) begin
            timeout_count <= (&timeout_count) ? timeout_count : timeout_count + CNT_W'(1);
            repeat_left   <= '0;
            state_q       <= S_IDLE;
          end
`else
          if (rx_done) begin
            pkt_count <= (&pkt_count) ? pkt_count : pkt_count + CNT_W'(1);
            pause_cnt <= pause_q;
            state_q   <= S_PAUSE;
          end
`endif
        end
        S_PAUSE: begin
          if (pause_cnt <= 8'd1) begin
            pause_cnt <= '0;
            if (repeat_left == '0) begin
              state_q <= S_IDLE;
            end else begin
              repeat_left <= repeat_left - 7'd1;
              timer       <= '0;
              state_q     <= S_ARM;
            end
          end else begin
            pause_cnt <= pause_cnt - 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofdmbbp_rx_cmd_sched.sv
// Scoreboard bench for ofdmbbp_rx_cmd_sched: expected receiver commands are queued when
// host commands are pushed and compared whenever the scheduler issues or starts a run.
module tb_ofdmbbp_rx_cmd_sched;

  localparam int TIMEOUT_W = 24;
  localparam int CNT_W     = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cfg_enable = 1'b1;
  logic [TIMEOUT_W-1:0] cfg_timeout = '0;
  logic                 cfg_abort = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [31:0]          cmd_data = '0;
  logic                 packet_detect = 1'b0;
  logic                 rx_cmd_valid;
  logic                 rx_cmd_ready = 1'b1;
  logic [7:0]           rx_cmd_length;
  logic [1:0]           rx_cmd_mode;
  logic [6:0]           rx_cmd_seed;
  logic                 rx_start;
  logic                 rx_done = 1'b0;
  logic                 busy;
  logic [2:0]           state;
  logic [CNT_W-1:0]     pkt_count;
  logic [CNT_W-1:0]     timeout_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hsCycle = -10;
  int startCount = 0;
  int startRun = 0;
  int popCount = 0;
  bit popNow = 1'b0;
  int expPkt = 0;
  int expTmo = 0;
  logic [31:0] fifoQ[$];
  logic [16:0] expQ[$];

  ofdmbbp_rx_cmd_sched #(.TIMEOUT_W(TIMEOUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_timeout(cfg_timeout),
    .cfg_abort(cfg_abort), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .packet_detect(packet_detect), .rx_cmd_valid(rx_cmd_valid), .rx_cmd_ready(rx_cmd_ready),
    .rx_cmd_length(rx_cmd_length), .rx_cmd_mode(rx_cmd_mode), .rx_cmd_seed(rx_cmd_seed),
    .rx_start(rx_start), .rx_done(rx_done), .busy(busy), .state(state),
    .pkt_count(pkt_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mkCmd(input logic [7:0] pause, input logic [6:0] rpt,
                                        input logic [6:0] seed, input logic [1:0] mode,
                                        input logic [7:0] len);
    return {pause, rpt, seed, mode, len};
  endfunction

  // Host FIFO model plus the expected receiver command for each run the command should produce.
  task automatic applyStimulus(input logic [31:0] cmd, input int runs);
    logic [16:0] f;
    f = {cmd[7:0], cmd[9:8], cmd[16:10]};
    fifoQ.push_back(cmd);
    for (int i = 0; i < runs; i++) expQ.push_back(f);
  endtask

  always @(negedge clk) begin
    popNow = cmd_ready;
    if (cmd_ready) popCount++;
  end

  always @(posedge clk) begin
    #1;
    if (popNow && fifoQ.size() > 0) void'(fifoQ.pop_front());
    cmd_valid = (fifoQ.size() > 0);
    cmd_data  = (fifoQ.size() > 0) ? fifoQ[0] : 32'h0;
  end

  // Receiver-side monitor: handshake timing, start width and command contents.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_cmd_valid) begin
        if (expQ.size() > 0)
          checkOutput("issue_fields", {rx_cmd_length, rx_cmd_mode, rx_cmd_seed}, expQ[0]);
        else
          checkOutput("issue_unexpected", rx_cmd_valid, 1'b0);
      end
      if (rx_start) begin
        startRun++;
        startCount++;
        checkOutput("start_width", startRun, 1);
        checkOutput("start_latency", cyc, hsCycle + 1);
        if (expQ.size() > 0)
          checkOutput("start_fields", {rx_cmd_length, rx_cmd_mode, rx_cmd_seed}, expQ.pop_front());
        else
          checkOutput("start_unexpected", rx_start, 1'b0);
      end else begin
        startRun = 0;
      end
      if (rx_cmd_valid && rx_cmd_ready) hsCycle = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitState(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (state !== s && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, state, s);
  endtask

  task automatic waitStart(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (rx_start !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, rx_start, 1'b1);
  endtask

  task automatic finishRun(input int doneDly, input int pause, input bit last);
    int hold;
    hold = (pause == 0) ? 1 : pause;
    waitStart("start_seen");
    repeat (doneDly) tick();
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    expPkt++;
    @(negedge clk);
    checkOutput("pause_entry", state, 3'd5);
    checkOutput("pkt_count", pkt_count, expPkt);
    for (int i = 1; i < hold; i++) begin
      tick();
      @(negedge clk);
    end
    checkOutput("pause_hold", state, 3'd5);
    tick();
    @(negedge clk);
    checkOutput("pause_exit", state, last ? 3'd0 : 3'd1);
  endtask

  task automatic doRun(input int detDly, input int doneDly, input int pause, input bit last);
    waitState(3'd1, "arm_wait");
    repeat (detDly) tick();
    packet_detect = 1'b1;
    tick();
    packet_detect = 1'b0;
    finishRun(doneDly, pause, last);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] c;
    int p0, s0;

    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_state", state, 3'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_valid", rx_cmd_valid, 1'b0);
    checkOutput("rst_start", rx_start, 1'b0);
    checkOutput("rst_pkt", pkt_count, 0);
    checkOutput("rst_tmo", timeout_count, 0);
    tick();
    rst = 1'b0;

    // Single run, no repeat, no pause.
    applyStimulus(32'h0000_0010, 1);
    doRun(5, 20, 0, 1'b1);
    checkOutput("t1_busy", busy, 1'b0);

    // Three runs with a 4-cycle pause and a single pop.
    p0 = popCount;
    c = mkCmd(8'd4, 7'd2, 7'h55, 2'd2, 8'hA5);
    applyStimulus(c, 3);
    doRun(3, 6, 4, 1'b0);
    doRun(2, 6, 4, 1'b0);
    doRun(4, 6, 4, 1'b1);
    checkOutput("t2_pops", popCount - p0, 1);

    // ARM timeout drops the first command, the second is popped right after.
    cfg_timeout = 24'd100;
    applyStimulus(mkCmd(8'd0, 7'd0, 7'h11, 2'd1, 8'h33), 0);
    applyStimulus(mkCmd(8'd0, 7'd0, 7'h22, 2'd3, 8'h44), 1);
    waitState(3'd1, "t3_arm");
    repeat (99) tick();
    @(negedge clk);
    checkOutput("t3_still_arm", state, 3'd1);
    tick();
    @(negedge clk);
    expTmo++;
    checkOutput("t3_dropped", state, 3'd0);
    checkOutput("t3_tmo", timeout_count, expTmo);
    tick();
    @(negedge clk);
    checkOutput("t3_next_pop", state, 3'd1);
    doRun(2, 5, 0, 1'b1);

    // Detect on the timeout cycle wins.
    cfg_timeout = 24'd10;
    applyStimulus(mkCmd(8'd1, 7'd0, 7'h7F, 2'd0, 8'hFF), 1);
    waitState(3'd1, "t4_arm");
    repeat (9) tick();
    packet_detect = 1'b1;
    tick();
    packet_detect = 1'b0;
    @(negedge clk);
    checkOutput("t4_issue", state, 3'd2);
    checkOutput("t4_tmo", timeout_count, expTmo);
    finishRun(3, 1, 1'b1);
    cfg_timeout = '0;

    // Receiver back-pressure holds the command.
    rx_cmd_ready = 1'b0;
    applyStimulus(mkCmd(8'd0, 7'd0, 7'h2A, 2'd1, 8'h5C), 1);
    waitState(3'd1, "t5_arm");
    packet_detect = 1'b1;
    tick();
    packet_detect = 1'b0;
    @(negedge clk);
    checkOutput("t5_issue", state, 3'd2);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      checkOutput("t5_valid_hold", rx_cmd_valid, 1'b1);
    end
    tick();
    rx_cmd_ready = 1'b1;
    finishRun(8, 0, 1'b1);

    // Abort in RUN with repeats outstanding.
    applyStimulus(mkCmd(8'd2, 7'd3, 7'h0F, 2'd2, 8'h21), 4);
    waitState(3'd1, "t6_arm");
    packet_detect = 1'b1;
    tick();
    packet_detect = 1'b0;
    waitStart("t6_start");
    repeat (5) tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("t6_abort_state", state, 3'd0);
    checkOutput("t6_abort_valid", rx_cmd_valid, 1'b0);
    checkOutput("t6_abort_pkt", pkt_count, expPkt);
    s0 = startCount;
    for (int i = 0; i < 5; i++) begin
      tick();
      packet_detect = (i % 2 == 0);
    end
    packet_detect = 1'b0;
    repeat (15) tick();
    @(negedge clk);
    checkOutput("t6_no_start", startCount, s0);
    checkOutput("t6_idle", state, 3'd0);

    // Reset in the middle of PAUSE.
    applyStimulus(mkCmd(8'd40, 7'd1, 7'h3C, 2'd3, 8'h99), 2);
    waitState(3'd1, "t7_arm");
    packet_detect = 1'b1;
    tick();
    packet_detect = 1'b0;
    waitStart("t7_start");
    repeat (3) tick();
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    expPkt++;
    @(negedge clk);
    checkOutput("t7_pause", state, 3'd5);
    checkOutput("t7_pkt", pkt_count, expPkt);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    expQ.delete();
    expPkt = 0;
    expTmo = 0;
    @(negedge clk);
    checkOutput("t7_rst_state", state, 3'd0);
    checkOutput("t7_rst_busy", busy, 1'b0);
    checkOutput("t7_rst_ready", cmd_ready, 1'b0);
    checkOutput("t7_rst_fields", {rx_cmd_length, rx_cmd_mode, rx_cmd_seed}, 17'd0);
    checkOutput("t7_rst_pkt", pkt_count, expPkt);
    checkOutput("t7_rst_tmo", timeout_count, expTmo);
    tick();
    rst = 1'b0;
    s0 = startCount;
    repeat (20) tick();
    @(negedge clk);
    checkOutput("t7_no_start", startCount, s0);
    checkOutput("t7_idle", state, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofdmbbp_rx_cmd_sched.md
Name: ofdmbbp_rx_cmd_sched

Overview:
Receive-command scheduler between the host command FIFO (AXI-written, read in the sample clock domain) and the OFDM receiver core.
- Pops one packed command and arms on the sync block's packet-detect strobe.
- Hands the command to the receiver and fires a one-cycle start.
- Waits for receiver completion, enforces the inter-packet pause and replays the command `repeat` times.
- Handles detect timeout and host abort, and exports status for the register map.

Parameters:
TIMEOUT_W, 24, width of the detect-timeout counter and of cfg_timeout
CNT_W, 16, width of the status counters

Ports:
clk  in  1  sample-rate clock (s_clk domain)
rst  in  1  synchronous, active-high reset
cfg_enable  in  1  scheduler enable; 0 stops new pops and leaves in-flight runs unaffected
cfg_timeout  in  TIMEOUT_W  maximum cycles in ARM before the command is dropped; 0 disables the timeout
cfg_abort  in  1  single-cycle host abort pulse
cmd_valid  in  1  command FIFO not empty
cmd_ready  out  1  pop strobe to command FIFO
cmd_data  in  32  {pause[31:24], repeat[23:17], seed[16:10], mode[9:8], length[7:0]}
packet_detect  in  1  sync packet-detect strobe
rx_cmd_valid  out  1  command valid to receiver
rx_cmd_ready  in  1  receiver accepts command
rx_cmd_length  out  8  latched length
rx_cmd_mode  out  2  latched mode
rx_cmd_seed  out  7  latched seed
rx_start  out  1  one-cycle receiver start
rx_done  in  1  one-cycle receiver completion pulse
busy  out  1  state != IDLE
state  out  3  encoded FSM state
pkt_count  out  CNT_W  completed runs
timeout_count  out  CNT_W  dropped-by-timeout commands

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state=IDLE; all outputs 0; latched fields, repeat_left, pause_cnt and timer cleared.
- State encodings: IDLE=0, ARM=1, ISSUE=2, START=3, RUN=4, PAUSE=5.
- IDLE:
  - cmd_ready = cfg_enable & cmd_valid (combinational).
  - On pop: latch all fields, set repeat_left=repeat, clear timer, go to ARM next cycle.
- ARM:
  - Timer increments each cycle.
  - packet_detect=1 goes to ISSUE. A detect in the same cycle as timeout takes priority over the timeout.
  - If cfg_timeout!=0 and timer==cfg_timeout-1 with no detect: timeout_count += 1 (saturating), drop the command, go to IDLE.
  - packet_detect is ignored in every state except ARM.
- ISSUE:
  - rx_cmd_valid=1 with stable fields.
  - When rx_cmd_valid & rx_cmd_ready: go to START.
  - rx_cmd_valid drops the cycle after the handshake.
- START: rx_start=1 for exactly one cycle, then go to RUN.
- RUN:
  - Wait for rx_done. rx_done is honoured only in RUN.
  - On rx_done: pkt_count += 1 (saturating), load pause_cnt=pause, go to PAUSE.
- PAUSE:
  - If pause_cnt==0, exit immediately (one cycle in PAUSE). Otherwise decrement each cycle and exit when it reaches 0.
  - On exit: if repeat_left==0 go to IDLE; else decrement repeat_left and go to ARM with the timer cleared.
- Total runs per command = repeat+1 (0..127 repeats).
- Latency:
  - Pop to ARM: 1 cycle.
  - Detect to rx_cmd_valid: 1 cycle.
  - Handshake to rx_start: 1 cycle.
  - rx_done to next ARM with pause=0: 2 cycles.
- cfg_abort:
  - Valid in any state; has highest priority over every other event in the same cycle.
  - Next state is IDLE with the command dropped and rx_cmd_valid/rx_start deasserted.
  - Counters are kept. No pop occurs in the abort cycle.
- cfg_enable=0 only gates the IDLE pop; a command in flight completes normally.
- Counters saturate at all-ones and do not wrap.
- Both counters clear only on rst.

Optional Feature:
Macro: OFDMBBP_RX_SCHED_RUN_WDOG_EN.
- When defined: the RUN state also counts cycles. If cfg_timeout!=0 and no rx_done arrives within cfg_timeout cycles, the block forces IDLE, drops the remaining repeats and increments timeout_count.
- When undefined: RUN waits for rx_done indefinitely. Only ARM times out.

Test Plan:
- Reset then cmd_data=0x00000010 (length 16, repeat 0, pause 0), detect 5 cycles after pop, rx_cmd_ready tied 1, rx_done 20 cycles after start -> rx_start asserted for exactly one cycle at handshake+1; pkt_count=1; returns to IDLE; state=0.
- Command with repeat=2, pause=4 and three detects -> three rx_start pulses; 4-cycle gap from rx_done to ARM after each run; pkt_count=3; cmd_ready pulses once.
- cfg_timeout=100 with no detect -> drop at cycle 100 after ARM entry; timeout_count=1; next FIFO command popped.
- Detect and timeout in the same cycle -> ISSUE entered; timeout_count unchanged.
- rx_cmd_ready held 0 for 10 cycles -> rx_cmd_valid and fields held stable; rx_start 1 cycle after ready rises.
- cfg_abort pulsed in RUN with repeat_left=3, then rst mid-PAUSE -> IDLE with no further rx_start; after rst, all outputs 0 and counters 0.
